// File: rtl/dwell_timer_pkg.sv
// Shared types, mode encodings and sizing helpers for the multichannel dwell timer.
package dwell_timer_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Prescaler counter width: enough bits to hold PRESCALE-1 with one bit of headroom.
  function automatic int unsigned presc_width(input int unsigned prescale);
    return 32'($clog2(prescale)) + 32'd1;
  endfunction

endpackage

// File: rtl/dwell_timer_chan.sv
// One dwell-timer channel: down-counter, stored limit/mode, busy and done strobe.
module dwell_timer_chan
  import dwell_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  chan_state_e      state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] lim_r, lim_nx;
  logic             mode_r, mode_nx;
  logic             done_r, done_nx;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      lim_r  <= '0;
      mode_r <= MODE_ONESHOT;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      lim_r  <= lim_nx;
      mode_r <= mode_nx;
      done_r <= done_nx;
    end
  end

  // Next-state: abort beats load, load beats a tick decrement.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lim_nx   = lim_r;
    mode_nx  = mode_r;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (load) begin
      if (limit != '0) begin
        state_nx = ST_RUN;
        cnt_nx   = limit;
        lim_nx   = limit;
        mode_nx  = mode;
      end else begin
        // Zero-length window: finishes immediately as a one-shot.
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        done_nx  = 1'b1;
      end
    end else if ((state == ST_RUN) && step) begin
      if (cnt > ONE) begin
        cnt_nx = cnt - ONE;
      end else begin
        done_nx = 1'b1;
        if (mode_r == MODE_RELOAD) begin
          cnt_nx = lim_r;
        end else begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      end
    end
  end

  assign q    = cnt;
  assign busy = (state == ST_RUN);
  assign done = done_r;

endmodule

// File: rtl/multichan_dwell_timer.sv
// NCH independent dwell timers sharing one prescaled count tick.
module multichan_dwell_timer
  import dwell_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [NCH-1:0]       load,
  input  logic [NCH-1:0]       abort,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] limit,
  output logic [NCH*WIDTH-1:0] q,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic                 tick
);

  localparam int unsigned     PW      = presc_width(PRESCALE);
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          step_c;

  // Prescaler: counts enabled cycles, emits a registered tick every PRESCALE of them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pcnt == PS_LAST) begin
        pcnt <= '0;
        tick <= 1'b1;
      end else begin
        pcnt <= pcnt + PW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // A tick only counts while the global enable is still high.
  assign step_c = tick & en;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    dwell_timer_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .step    (step_c),
      .load    (load[i]),
      .abort   (abort[i]),
      .mode    (mode[i]),
      .limit   (limit[i*WIDTH +: WIDTH]),
      .q       (q[i*WIDTH +: WIDTH]),
      .busy    (busy[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_multichan_dwell_timer.sv
// Bench for multichan_dwell_timer: directed table, corner sequences and random vs. reference model.
module tb_multichan_dwell_timer;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   load = '0;
  logic [N-1:0]   abort = '0;
  logic [N-1:0]   mode = '0;
  logic [N*W-1:0] limit = '0;

  logic [N*W-1:0] q1, q4;
  logic [N-1:0]   busy1, busy4, done1, done4;
  logic           tick1, tick4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multichan_dwell_timer #(.WIDTH(W), .NCH(N), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .abort(abort), .mode(mode),
    .limit(limit), .q(q1), .busy(busy1), .done(done1), .tick(tick1)
  );

  multichan_dwell_timer #(.WIDTH(W), .NCH(N), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .abort(abort), .mode(mode),
    .limit(limit), .q(q4), .busy(busy4), .done(done4), .tick(tick4)
  );

  // Reference model: index 0 is the PRESCALE=1 instance, index 1 the PRESCALE=4 instance.
  int unsigned m_q    [2][N];
  int unsigned m_lim  [2][N];
  bit          m_busy [2][N];
  bit          m_done [2][N];
  bit          m_mode [2][N];
  int unsigned m_enc  [2];
  bit          m_tick [2];
  int unsigned presc  [2];

  typedef struct {
    bit          en;
    bit          ld;
    bit          ab;
    bit          md;
    logic [W-1:0] lim;
    logic [W-1:0] xq;
    bit          xb;
    bit          xd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit e, bit l, bit a, bit m, int unsigned li,
                              int unsigned xq, bit xb, bit xd);
    vec_t v;
    v.en = e; v.ld = l; v.ab = a; v.md = m;
    v.lim = W'(li); v.xq = W'(xq); v.xb = xb; v.xd = xd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_enc[d] = 0;
      m_tick[d] = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_q[d][c] = 0; m_lim[d][c] = 0; m_busy[d][c] = 1'b0;
        m_done[d][c] = 1'b0; m_mode[d][c] = 1'b0;
      end
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit tk;
      tk = m_tick[d];
      if (en) begin
        m_enc[d] = m_enc[d] + 1;
        m_tick[d] = ((m_enc[d] % presc[d]) == 0);
      end else begin
        m_tick[d] = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
        int unsigned lv;
        lv = int'(limit[c*W +: W]);
        m_done[d][c] = 1'b0;
        if (abort[c]) begin
          m_q[d][c] = 0; m_busy[d][c] = 1'b0;
        end else if (load[c]) begin
          if (lv != 0) begin
            m_q[d][c] = lv; m_lim[d][c] = lv; m_mode[d][c] = mode[c]; m_busy[d][c] = 1'b1;
          end else begin
            m_q[d][c] = 0; m_busy[d][c] = 1'b0; m_done[d][c] = 1'b1;
          end
        end else if (m_busy[d][c] && tk && en) begin
          if (m_q[d][c] > 1) begin
            m_q[d][c] = m_q[d][c] - 1;
          end else begin
            m_done[d][c] = 1'b1;
            if (m_mode[d][c]) m_q[d][c] = m_lim[d][c];
            else begin m_q[d][c] = 0; m_busy[d][c] = 1'b0; end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [63:0]  eq;
      logic [N-1:0] eb, ed;
      eq = '0; eb = '0; ed = '0;
      for (int c = 0; c < N; c++) begin
        eq[c*W +: W] = W'(m_q[d][c]);
        eb[c] = m_busy[d][c];
        ed[c] = m_done[d][c];
      end
      if (d == 0) begin
        chk("p1 q", q1, eq); chk("p1 busy", 64'(busy1), 64'(eb));
        chk("p1 done", 64'(done1), 64'(ed)); chk("p1 tick", 64'(tick1), 64'(m_tick[0]));
      end else begin
        chk("p4 q", q4, eq); chk("p4 busy", 64'(busy4), 64'(eb));
        chk("p4 done", 64'(done4), 64'(ed)); chk("p4 tick", 64'(tick4), 64'(m_tick[1]));
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    load = '0; abort = '0; mode = '0; limit = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_in();
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int cnt;
    presc[0] = 1;
    presc[1] = 4;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
    en = 1'b1;
    step();

    // Directed table on channel 0 (PRESCALE=1 instance)
    tbl.push_back(mk(1,1,0,0,5, 5,1,0));
    tbl.push_back(mk(1,0,0,0,0, 4,1,0));
    tbl.push_back(mk(1,0,0,0,0, 3,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,1,0,7, 0,0,0));
    tbl.push_back(mk(1,1,0,0,2, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,1,0,0,9, 9,1,0));
    tbl.push_back(mk(1,0,0,0,0, 8,1,0));
    tbl.push_back(mk(0,0,0,0,0, 8,1,0));
    tbl.push_back(mk(0,0,0,0,0, 8,1,0));
    tbl.push_back(mk(1,0,0,0,0, 8,1,0));
    tbl.push_back(mk(1,0,0,0,0, 7,1,0));
    tbl.push_back(mk(1,1,0,1,2, 2,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,1));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0));
    tbl.push_back(mk(1,0,1,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; load[0] = tbl[i].ld; abort[0] = tbl[i].ab;
      mode[0] = tbl[i].md; limit[W-1:0] = tbl[i].lim;
      step();
      chk($sformatf("tbl[%0d] q0", i), 64'(q1[W-1:0]), 64'(tbl[i].xq));
      chk($sformatf("tbl[%0d] busy0", i), 64'(busy1[0]), 64'(tbl[i].xb));
      chk($sformatf("tbl[%0d] done0", i), 64'(done1[0]), 64'(tbl[i].xd));
    end
    clear_in();
    en = 1'b1;

    // Auto-reload on channel 1, limit 3, then abort
    begin
      int unsigned xq [6];
      bit          xd [6];
      xq = '{2, 1, 3, 2, 1, 3};
      xd = '{0, 0, 1, 0, 0, 1};
      load[1] = 1'b1; mode[1] = 1'b1; limit[W +: W] = W'(3);
      step();
      clear_in();
      chk("reload q1 start", 64'(q1[W +: W]), 64'd3);
      for (int i = 0; i < 6; i++) begin
        step();
        chk($sformatf("reload q1[%0d]", i), 64'(q1[W +: W]), 64'(xq[i]));
        chk($sformatf("reload done1[%0d]", i), 64'(done1[1]), 64'(xd[i]));
        chk($sformatf("reload busy1[%0d]", i), 64'(busy1[1]), 64'd1);
      end
      abort[1] = 1'b1;
      step();
      abort = '0;
      chk("abort q1", 64'(q1[W +: W]), 64'd0);
      chk("abort busy1", 64'(busy1[1]), 64'd0);
      chk("abort done1", 64'(done1[1]), 64'd0);
    end

    // Prescale=4 latency from a fresh prescaler phase
    do_reset();
    reset_n = 1'b1; en = 1'b1;
    load[2] = 1'b1; limit[2*W +: W] = W'(2);
    step();
    clear_in();
    cnt = 0;
    while (cnt < 100) begin
      step();
      cnt++;
      if (done4[2]) break;
    end
    chk("p4 latency", 64'(cnt), 64'd8);

    // Same, with en low for 10 cycles mid-count
    do_reset();
    reset_n = 1'b1; en = 1'b1;
    load[2] = 1'b1; limit[2*W +: W] = W'(2);
    step();
    clear_in();
    step();
    cnt = 1;
    en = 1'b0;
    repeat (10) begin step(); cnt++; end
    chk("p4 frozen q2", 64'(q4[2*W +: W]), 64'd2);
    en = 1'b1;
    while (cnt < 100) begin
      step();
      cnt++;
      if (done4[2]) break;
    end
    chk("p4 latency frozen", 64'(cnt), 64'd18);

    // Async reset between edges while channels run
    for (int c = 0; c < N; c++) begin load[c] = 1'b1; limit[c*W +: W] = W'(10 + c); end
    step();
    clear_in();
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async q p1", q1, 64'd0);   chk("async busy p1", 64'(busy1), 64'd0);
    chk("async done p1", 64'(done1), 64'd0); chk("async tick p1", 64'(tick1), 64'd0);
    chk("async q p4", q4, 64'd0);   chk("async busy p4", 64'(busy4), 64'd0);
    chk("async done p4", 64'(done4), 64'd0); chk("async tick p4", 64'(tick4), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
    repeat (5) step();
    chk("post-reset idle busy", 64'(busy1), 64'd0);

    // Full-range limit on channel 3: 65535 ticks, never wraps
    load[3] = 1'b1; limit[3*W +: W] = 16'hFFFF;
    step();
    clear_in();
    cnt = 0;
    while (cnt < 70000) begin
      step();
      cnt++;
      if (done1[3]) break;
    end
    chk("ffff latency", 64'(cnt), 64'd65535);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < N; c++) begin
        load[c]  = ($urandom_range(0, 19) == 0);
        abort[c] = ($urandom_range(0, 39) == 0);
        mode[c]  = 1'($urandom_range(0, 1));
        limit[c*W +: W] = W'($urandom_range(0, 12));
      end
      step();
    end
    clear_in();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multichan_dwell_timer.md
Name: multichan_dwell_timer

Overview:
- Parametrised successor to the single down-counter used to time photonic-switch dwell windows.
- Provides NCH independent down-counting timers that share one prescaled tick.
- Each channel runs in one-shot or auto-reload mode and raises a one-cycle done strobe at terminal count.
- Sits between the command decoder (which issues load and limit) and the switch-drive sequencer (which consumes done and busy).

Parameters:
- WIDTH, 16, bits per channel counter and limit.
- NCH, 4, number of independent channels.
- PRESCALE, 1, clk cycles per count tick (1 = count every cycle; must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  global count enable; gates the prescaler and all channel decrements.
- load  input  NCH  per-channel start strobe; captures that channel's limit slice.
- abort  input  NCH  per-channel stop; clears the counter and busy without asserting done.
- mode  input  NCH  per-channel mode, sampled at load: 0 = one-shot, 1 = auto-reload.
- limit  input  NCH*WIDTH  start values; channel i uses bits [i*WIDTH +: WIDTH].
- q  output  NCH*WIDTH  current count per channel (registered).
- busy  output  NCH  channel i is counting.
- done  output  NCH  one-cycle strobe at terminal count.
- tick  output  1  registered prescaler strobe, for debug and test.

Behaviour:
- Reset (async, reset_n=0): q=0, busy=0, done=0, tick=0, prescaler count=0, stored limit and mode registers=0.
- Outputs stay at these values while reset_n=0. Release is synchronous to clk.
- Prescaler:
  - Counts clk cycles only while en=1 and holds while en=0.
  - tick=1 for one cycle every PRESCALE enabled cycles.
  - PRESCALE=1 gives tick=en, registered one cycle late.
  - Width is clog2(PRESCALE)+1.
- Per-channel state: IDLE (busy=0) and RUN (busy=1).
- Priority per channel, highest first: abort, load, tick decrement.
- abort=1: q<=0, busy<=0, done<=0, regardless of load or tick in the same cycle.
- load=1 with limit!=0:
  - q<=limit, the limit register is stored, mode is latched, busy<=1.
  - A tick in the same cycle is ignored.
  - Loading while in RUN restarts the channel with the new value. No done is issued for the interrupted count.
- load=1 with limit==0: q<=0, busy<=0, and done<=1 on the next cycle in either mode. This is a degenerate one-shot.
- RUN with tick=1 and q>1: q<=q-1.
- RUN with tick=1 and q==1:
  - done<=1 for exactly one cycle.
  - One-shot: q<=0, busy<=0.
  - Auto-reload: q<=stored limit, busy stays 1. The period is exactly limit ticks with no dead cycle.
- IDLE: q holds and never wraps below 0. A tick has no effect.
- en=0: every channel holds q and busy. load and abort still act.
- done is registered. It rises on the clock edge where q takes its terminal or reloaded value.
- Latency:
  - load to first decrement: the next tick after the load cycle.
  - One-shot total: limit ticks from load to done.
- Channels are fully independent apart from the shared tick.

Decomposition:
- Package dwell_timer_pkg holds:
  - localparams MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1;
  - a function that computes prescaler width from PRESCALE.
- Sub-module dwell_timer_chan (WIDTH parameter) holds one channel's counter, stored limit, mode, busy and done logic.
- The top level instantiates the prescaler and a generate loop of NCH dwell_timer_chan instances.

Test Plan:
- Reset and one-shot: reset_n low then high; WIDTH=16, PRESCALE=1, en=1; load[0] with limit=5, mode=0 -> q0 runs 5,4,3,2,1,0; done[0] high exactly one cycle, the cycle q0 becomes 0; busy[0] drops the same cycle; other channels stay q=0.
- Auto-reload: channel 1, limit=3, mode=1 -> done[1] pulses every 3 cycles; q1 cycles 3,2,1,3,2,1; busy[1] stays 1; abort[1] -> q1=0, busy[1]=0, no done.
- Prescale and enable: PRESCALE=4, load[2] with limit=2 -> done[2] 8 enabled cycles after load; deassert en for 10 cycles mid-count -> q2 frozen and done delayed by exactly 10 cycles.
- Simultaneous events:
  - abort and load in the same cycle -> channel ends IDLE with q=0.
  - load during RUN at q=1 coinciding with a tick -> q=new limit and no done.
- Edge values:
  - load with limit=0 -> done one cycle later, busy stays 0.
  - load with limit=16'hFFFF, PRESCALE=1 -> done after 65535 cycles; q never wraps.
- Async reset mid-count: drop reset_n between clock edges while channels are in RUN -> q, busy, done and tick are 0 immediately; after release, channels stay IDLE until a new load.
